// File: rtl/bfly_addsub_pkg.sv
// Shared NTT package: default datapath width, modulus, multiplier latency and stage size,
// common to the butterfly, the multiplier and the address generator.
package bfly_addsub_pkg;

  localparam int NTT_DATA_WIDTH = 14;
  localparam int NTT_Q          = 3329;
  localparam int NTT_MUL_LAT    = 4;
  localparam int NTT_N_PAIRS    = 256;

endpackage

// File: rtl/bfly_addsub_if.sv
// Butterfly add/sub stream interface: operand side in, result side out.
// The half_in signal exists only when BFLY_HALF_EN is defined.
interface bfly_addsub_if import bfly_addsub_pkg::*; #(
  parameter int DATA_WIDTH = NTT_DATA_WIDTH
);

  logic                  valid_in;
  logic [DATA_WIDTH-1:0] a_in;
  logic [DATA_WIDTH-1:0] p_in;
`ifdef BFLY_HALF_EN
  logic                  half_in;
`endif
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] sum_out;
  logic [DATA_WIDTH-1:0] diff_out;
  logic                  last_out;

  modport master (
`ifdef BFLY_HALF_EN
    output half_in,
`endif
    output valid_in, a_in, p_in,
    input  valid_out, sum_out, diff_out, last_out
  );

  modport slave (
`ifdef BFLY_HALF_EN
    input  half_in,
`endif
    input  valid_in, a_in, p_in,
    output valid_out, sum_out, diff_out, last_out
  );

endinterface

// File: rtl/delay_line.sv
// Fixed-depth shift register with synchronous clear; aligns operand side-band with
// the multiplier product.
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/bfly_addsub.sv
// NTT butterfly add/sub stage: (a+p) mod Q and (a-p) mod Q with stage-end pulse.
// Optional halving of both results (INTT) is enabled by the BFLY_HALF_EN macro.
module bfly_addsub import bfly_addsub_pkg::*; #(
  parameter int DATA_WIDTH = NTT_DATA_WIDTH,
  parameter int Q          = NTT_Q,
  parameter int MUL_LAT    = NTT_MUL_LAT,
  parameter int N_PAIRS    = NTT_N_PAIRS
) (
  input  logic         clk,
  input  logic         rst,
  bfly_addsub_if.slave bus
);

`ifdef BFLY_HALF_EN
  localparam int DL_W = DATA_WIDTH + 2;
`else
  localparam int DL_W = DATA_WIDTH + 1;
`endif
  localparam int                  CNT_W    = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam logic [DATA_WIDTH:0] QW       = (DATA_WIDTH+1)'(Q);
  localparam logic [CNT_W-1:0]    LAST_IDX = CNT_W'(N_PAIRS - 1);

  logic [DL_W-1:0]       dlIn, dlOut;
  logic                  dValid;
  logic [DATA_WIDTH-1:0] dA;

`ifdef BFLY_HALF_EN
  logic dHalf;
  assign dlIn = {bus.valid_in, bus.half_in, bus.a_in};
  assign {dValid, dHalf, dA} = dlOut;

  // Odd values get +Q first so the shift stays an exact division modulo Q.
  function automatic logic [DATA_WIDTH-1:0] halve(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH:0] t;
    t = {1'b0, x} + (x[0] ? QW : '0);
    return DATA_WIDTH'(t >> 1);
  endfunction
`else
  assign dlIn = {bus.valid_in, bus.a_in};
  assign {dValid, dA} = dlOut;
`endif

  delay_line #(
    .WIDTH (DL_W),
    .DEPTH (MUL_LAT)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .d_i (dlIn),
    .q_o (dlOut)
  );

  logic [DATA_WIDTH:0]   sumRaw, diffRaw;
  logic [DATA_WIDTH-1:0] sumMod, diffMod;

  always_comb begin
    sumRaw  = {1'b0, dA} + {1'b0, bus.p_in};
    diffRaw = {1'b0, dA} - {1'b0, bus.p_in};
    sumMod  = (sumRaw >= QW) ? DATA_WIDTH'(sumRaw - QW) : sumRaw[DATA_WIDTH-1:0];
    diffMod = diffRaw[DATA_WIDTH] ? DATA_WIDTH'(diffRaw + QW) : diffRaw[DATA_WIDTH-1:0];
  end

  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0]      pairCnt_q, pairCnt_d;

  always_comb begin
    valid_d   = dValid;
    last_d    = 1'b0;
    sum_d     = sum_q;
    diff_d    = diff_q;
    pairCnt_d = pairCnt_q;
    if (dValid) begin
`ifdef BFLY_HALF_EN
      sum_d  = dHalf ? halve(sumMod)  : sumMod;
      diff_d = dHalf ? halve(diffMod) : diffMod;
`else
      sum_d  = sumMod;
      diff_d = diffMod;
`endif
      last_d    = (pairCnt_q == LAST_IDX);
      pairCnt_d = last_d ? '0 : pairCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      sum_q     <= '0;
      diff_q    <= '0;
      pairCnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      last_q    <= last_d;
      sum_q     <= sum_d;
      diff_q    <= diff_d;
      pairCnt_q <= pairCnt_d;
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.last_out  = last_q;
  assign bus.sum_out   = sum_q;
  assign bus.diff_out  = diff_q;

endmodule

// File: tb/tb_bfly_addsub.sv
// Scoreboard bench for bfly_addsub: random and directed pairs against a modular-arithmetic
// model; exercises the BFLY_HALF_EN halving path when that macro is defined.
module tb_bfly_addsub;
  import bfly_addsub_pkg::*;

  localparam int DW  = NTT_DATA_WIDTH;
  localparam int Q   = NTT_Q;
  localparam int LAT = NTT_MUL_LAT;
  localparam int NP  = NTT_N_PAIRS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bfly_addsub_if #(.DATA_WIDTH(DW)) bus ();

  bfly_addsub #(
    .DATA_WIDTH (DW),
    .Q          (Q),
    .MUL_LAT    (LAT),
    .N_PAIRS    (NP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int outCycle;
    int sum;
    int diff;
    bit last;
  } expT;

  expT expQ[$];
  expT monE;
  int  pForCycle[int];
  int  compared   = 0;
  int  mismatched = 0;
  int  cycleCnt   = 0;
  int  modelCount = 0;
  int  holdSum    = 0;
  int  holdDiff   = 0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  function automatic int modHalf(input int x);
    return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycleCnt, act, exp);
    end
  endtask

  // Drives one cycle; a valid pair schedules its product LAT cycles later and queues the result.
  task automatic applyStimulus(input bit v, input int a, input int p, input bit h);
    int  c;
    int  s;
    int  d;
    expT e;
    c = cycleCnt;
    bus.valid_in = v;
    bus.a_in     = DW'(a);
`ifdef BFLY_HALF_EN
    bus.half_in  = h;
`endif
    bus.p_in = pForCycle.exists(c) ? DW'(pForCycle[c]) : DW'($urandom_range(0, Q - 1));
    if (v) begin
      pForCycle[c + LAT] = p;
      s = (a + p) % Q;
      d = (a - p + Q) % Q;
`ifdef BFLY_HALF_EN
      if (h) begin
        s = modHalf(s);
        d = modHalf(d);
      end
`endif
      e.outCycle = c + LAT + 1;
      e.sum      = s;
      e.diff     = d;
      e.last     = (modelCount == NP - 1);
      expQ.push_back(e);
      modelCount = (modelCount + 1) % NP;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, $urandom_range(0, Q - 1), 0, 1'b0);
  endtask

  task automatic randPair(input bit h);
    applyStimulus(1'b1, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1), h);
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    bus.valid_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.p_in = DW'($urandom_range(0, Q - 1));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    expQ.delete();
    modelCount = 0;
    holdSum    = 0;
    holdDiff   = 0;
    checkOutput("rst_valid_out", int'(bus.valid_out), 0);
    checkOutput("rst_sum_out",   int'(bus.sum_out),   0);
    checkOutput("rst_diff_out",  int'(bus.diff_out),  0);
    checkOutput("rst_last_out",  int'(bus.last_out),  0);
  endtask

  // Monitor: every presented pair must match the queue head, idle cycles must hold the last pair.
  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_valid at cycle %0d: got valid_out=1, expected no output",
                 cycleCnt);
      end else begin
        monE = expQ.pop_front();
        checkOutput("out_cycle", cycleCnt,           monE.outCycle);
        checkOutput("sum_out",   int'(bus.sum_out),  monE.sum);
        checkOutput("diff_out",  int'(bus.diff_out), monE.diff);
        checkOutput("last_out",  int'(bus.last_out), int'(monE.last));
        holdSum  = monE.sum;
        holdDiff = monE.diff;
      end
    end else if (rst === 1'b0) begin
      checkOutput("idle_last_out", int'(bus.last_out), 0);
      checkOutput("hold_sum_out",  int'(bus.sum_out),  holdSum);
      checkOutput("hold_diff_out", int'(bus.diff_out), holdDiff);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.valid_in = 1'b0;
    bus.a_in     = '0;
    bus.p_in     = '0;
`ifdef BFLY_HALF_EN
    bus.half_in  = 1'b0;
`endif
    @(posedge clk);
    #1;
    doReset(3);

    applyStimulus(1'b1, 3000, 500, 1'b0);
    idle(7);
    applyStimulus(1'b1, 100, 3328, 1'b0);
    applyStimulus(1'b1, 0, 0, 1'b0);
    idle(3);
    randPair(1'b0);
    idle(1);
    randPair(1'b0);
    randPair(1'b0);
    idle(6);
`ifdef BFLY_HALF_EN
    applyStimulus(1'b1, 3000, 500, 1'b1);
    idle(6);
`endif

    // 100 pairs drain, the next three are still in the pipe when reset hits.
    doReset(1);
    for (int i = 0; i < 103; i++) randPair(1'b0);
    idle(1);
    doReset(1);
    idle(2);

    for (int i = 0; i < NP + 1; i++) randPair(1'b0);
    idle(3);

    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 9) < 7) randPair(1'($urandom_range(0, 1)));
      else idle(1);
    end

    for (int i = 0; i < 20 && expQ.size() != 0; i++) idle(1);
    checkOutput("drain_pending", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
